// File: rtl/pixel_array_pkg.sv
// Shared types for the pixel array: sequencer states, array control bundle, row-index width.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package pixel_array_pkg;

  // Width of the latched exposure length and of the phase counter
  localparam int EXP_W = 16;

  // Frame sequencer states, in the order a normal frame visits them
  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ERASE       = 3'd1,
    S_EXPOSE      = 3'd2,
    S_CONVERT     = 3'd3,
    S_READ_SETTLE = 3'd4,
    S_READ_HOLD   = 3'd5,
    S_DONE        = 3'd6
  } state_t;

  // Controls shared by every pixel. The per-row READ lines are ROWS wide,
  // so they travel next to this struct as their own vector.
  typedef struct packed {
    logic bias;
    logic ramp;
    logic erase;
    logic mem_reset;
    logic expose;
  } ctrl_t;

  // Row index width; a single-row array still needs one bit
  function automatic int row_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/PIXEL_SENSOR.sv
// Behavioural stand-in for one sensor pixel: integrates light, latches the ramp code at comparator flip.
// Latency: charge and memory update on the clock edge; DATA is driven combinationally while READ=1.
// Backpressure: none; the pixel only drives its column bus while READ is high.
module PIXEL_SENSOR #(
  parameter int DW   = 8,
  parameter int GAIN = 1
) (
  input  logic          clk,
  input  logic          bias,
  input  logic          ramp,
  input  logic          erase,
  input  logic          mem_reset,
  input  logic          expose,
  input  logic          read,
  inout  wire  [DW-1:0] data
);

  localparam int FULL = (1 << DW) - 1;

  logic [DW-1:0] charge;
  logic [DW-1:0] charge_nxt;
  logic [DW-1:0] mem;
  logic          flipped;
  int            sum;

  // Saturating integration step; GAIN stands in for this site's illumination
  always_comb begin
    sum        = int'(charge) + GAIN;
    charge_nxt = (sum > FULL) ? DW'(FULL) : DW'(sum);
  end

  // Photodiode charge: cleared by erase, accumulates each exposed cycle
  always_ff @(posedge clk) begin
    if (erase) begin
      charge <= '0;
    end else if (expose && bias) begin
      charge <= charge_nxt;
    end
  end

  // Sample-and-hold: capture the ramp code on the first cycle it reaches the charge level
  always_ff @(posedge clk) begin
    if (mem_reset) begin
      mem     <= '0;
      flipped <= 1'b0;
    end else if (ramp && bias && !flipped && (data >= charge)) begin
      mem     <= data;
      flipped <= 1'b1;
    end
  end

  assign data = read ? mem : 'z;

endmodule

// File: rtl/pixel_array_core.sv
// ROWS x COLS grid of PIXEL_SENSOR macros; pixels in a column share one DW-bit bus.
// Latency: none of its own; purely structural wiring of shared controls and READ lines.
// Backpressure: none; at most one row drives the column buses at a time.
module pixel_array_core
  import pixel_array_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  ctrl_t                ctl,
  input  logic [ROWS-1:0]      read,
  inout  wire  [COLS*DW-1:0]   col_bus
);

  // Each site gets a distinct response so every pixel converts to its own code
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      PIXEL_SENSOR #(
        .DW   (DW),
        .GAIN (r * COLS + c + 1)
      ) ps (
        .clk       (clk),
        .bias      (ctl.bias),
        .ramp      (ctl.ramp),
        .erase     (ctl.erase),
        .mem_reset (ctl.mem_reset),
        .expose    (ctl.expose),
        .read      (read[r]),
        .data      (col_bus[c*DW +: DW])
      );
    end
  end

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer: erase, expose, ramp convert, then stream each row out on valid/ready.
// Latency: ERASE_CYCLES + exposure + 2**DW + SETTLE_CYCLES cycles from start to the first row beat.
// Backpressure: a row holds pix_data/pix_row until pix_ready; the next row is not read until then.
module pixel_array_ctrl
  import pixel_array_pkg::*;
#(
  parameter  int ROWS          = 2,
  parameter  int COLS          = 2,
  parameter  int DW            = 8,
  parameter  int ERASE_CYCLES  = 5,
  parameter  int SETTLE_CYCLES = 2,
  localparam int RW            = row_width(ROWS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [EXP_W-1:0]   exposure,
  output logic               busy,
  output logic               frame_done,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [RW-1:0]      pix_row,
  output logic [COLS*DW-1:0] pix_data
);

  localparam logic [EXP_W-1:0] ERASE_LAST  = EXP_W'(ERASE_CYCLES - 1);
  localparam logic [EXP_W-1:0] SETTLE_LAST = EXP_W'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0]    ROW_LAST    = RW'(ROWS - 1);

  state_t             state;
  state_t             state_nxt;
  ctrl_t              ctl;
  logic               read_en;
  logic               bus_drive;
  logic [ROWS-1:0]    read;
  logic [EXP_W-1:0]   phase_cnt;
  logic [EXP_W-1:0]   exp_len;
  logic [DW-1:0]      conv_cnt;
  logic [RW-1:0]      row;
  wire  [COLS*DW-1:0] col_bus;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state controls; abort overrides every other transition
  always_comb begin
    state_nxt = state;
    ctl       = '0;
    read_en   = 1'b0;
    bus_drive = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ERASE;
      end
      S_ERASE: begin
        ctl.bias      = 1'b1;
        ctl.erase     = 1'b1;
        ctl.mem_reset = 1'b1;
        if (phase_cnt == ERASE_LAST) state_nxt = S_EXPOSE;
      end
      S_EXPOSE: begin
        ctl.bias   = 1'b1;
        ctl.expose = 1'b1;
        if (phase_cnt == exp_len - 16'd1) state_nxt = S_CONVERT;
      end
      S_CONVERT: begin
        ctl.bias  = 1'b1;
        ctl.ramp  = 1'b1;
        bus_drive = 1'b1;
        if (conv_cnt == '1) state_nxt = S_READ_SETTLE;
      end
      S_READ_SETTLE: begin
        read_en = 1'b1;
        if (phase_cnt == SETTLE_LAST) state_nxt = S_READ_HOLD;
      end
      S_READ_HOLD: begin
        read_en = 1'b1;
        if (pix_ready) state_nxt = (row == ROW_LAST) ? S_DONE : S_READ_SETTLE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Phase timer for the fixed-length states; restarts on every state change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_cnt <= '0;
    end else if (state_nxt != state) begin
      phase_cnt <= '0;
    end else if (state == S_ERASE || state == S_EXPOSE || state == S_READ_SETTLE) begin
      phase_cnt <= phase_cnt + 16'd1;
    end else begin
      phase_cnt <= '0;
    end
  end

  // Exposure length captured on an accepted start; zero is stretched to one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_len <= '0;
    end else if (state == S_IDLE && state_nxt == S_ERASE) begin
      exp_len <= (exposure == '0) ? 16'd1 : exposure;
    end
  end

  // Ramp code: steps once per CONVERT cycle and returns to 0 when CONVERT ends
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conv_cnt <= '0;
    end else if (state == S_CONVERT && state_nxt == S_CONVERT) begin
      conv_cnt <= conv_cnt + 1'b1;
    end else begin
      conv_cnt <= '0;
    end
  end

  // Row pointer: starts at 0 for readout, advances after each accepted beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
    end else if (state_nxt == S_IDLE || state == S_CONVERT) begin
      row <= '0;
    end else if (state == S_READ_HOLD && state_nxt == S_READ_SETTLE) begin
      row <= row + 1'b1;
    end
  end

  // Output beat: capture the settled column buses, then hold until accepted or aborted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid <= 1'b0;
      pix_row   <= '0;
      pix_data  <= '0;
    end else if (state == S_READ_SETTLE && state_nxt == S_READ_HOLD) begin
      pix_valid <= 1'b1;
      pix_row   <= row;
      pix_data  <= col_bus;
    end else if (state_nxt != S_READ_HOLD) begin
      pix_valid <= 1'b0;
    end
  end

  // One READ line at most, and only while reading; the controller drives the
  // buses only in CONVERT, so the two drivers can never overlap
  assign read       = read_en ? (ROWS'(1) << row) : '0;
  assign col_bus    = bus_drive ? {COLS{conv_cnt}} : 'z;
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  pixel_array_core #(
    .ROWS (ROWS),
    .COLS (COLS),
    .DW   (DW)
  ) u_core (
    .clk     (clk),
    .ctl     (ctl),
    .read    (read),
    .col_bus (col_bus)
  );

endmodule
